// File: rtl/riscv_id2ex_stage.sv
// ID/EX pipeline register: captures decoded ID fields for EX, detects load-use
// hazards, inserts bubbles on flush/load-use, and bypasses WB data into ID operands.
module riscv_id2ex_stage #(
  parameter int unsigned RF_ADDR_WIDTH = 5,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned CTRL_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_id,
  input  logic [XLEN-1:0]          pc_id,
  input  logic [RF_ADDR_WIDTH-1:0] rs1_id,
  input  logic [RF_ADDR_WIDTH-1:0] rs2_id,
  input  logic [1:0]               rs_used_id,
  input  logic [RF_ADDR_WIDTH-1:0] rd_id,
  input  logic [XLEN-1:0]          rs1_rdata,
  input  logic [XLEN-1:0]          rs2_rdata,
  input  logic [XLEN-1:0]          imm_id,
  input  logic [CTRL_WIDTH-1:0]    ctrl_id,
  input  logic [RF_ADDR_WIDTH-1:0] rd_mem2wb_ff,
  input  logic                     reg_write_mem2wb_ff,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     flush_ex,
  input  logic                     stall_ex,
  output logic                     valid_id2ex_ff,
  output logic [XLEN-1:0]          pc_id2ex_ff,
  output logic [RF_ADDR_WIDTH-1:0] rs1_id2ex_ff,
  output logic [RF_ADDR_WIDTH-1:0] rs2_id2ex_ff,
  output logic [RF_ADDR_WIDTH-1:0] rd_id2ex_ff,
  output logic [XLEN-1:0]          rs1_data_id2ex_ff,
  output logic [XLEN-1:0]          rs2_data_id2ex_ff,
  output logic [XLEN-1:0]          imm_id2ex_ff,
  output logic [CTRL_WIDTH-1:0]    ctrl_id2ex_ff,
  output logic                     load_use_stall
);

  logic            ex_is_load;
  logic            rs1_dep;
  logic            rs2_dep;
  logic            rs1_wb_hit;
  logic            rs2_wb_hit;
  logic            bubble;
  logic [XLEN-1:0] rs1_operand;
  logic [XLEN-1:0] rs2_operand;

  always_comb begin
    ex_is_load     = valid_id2ex_ff && ctrl_id2ex_ff[1] && (rd_id2ex_ff != '0);
    rs1_dep        = rs_used_id[0] && (rs1_id == rd_id2ex_ff);
    rs2_dep        = rs_used_id[1] && (rs2_id == rd_id2ex_ff);
    load_use_stall = valid_id && ex_is_load && (rs1_dep || rs2_dep) && !flush_ex && !stall_ex;
    bubble         = flush_ex || load_use_stall;
  end

  // x0 is never bypassed; the regfile already returns zero for it
  always_comb begin
    rs1_wb_hit  = reg_write_mem2wb_ff && (rd_mem2wb_ff != '0) && (rd_mem2wb_ff == rs1_id);
    rs2_wb_hit  = reg_write_mem2wb_ff && (rd_mem2wb_ff != '0) && (rd_mem2wb_ff == rs2_id);
    rs1_operand = rs1_wb_hit ? wb_data : rs1_rdata;
    rs2_operand = rs2_wb_hit ? wb_data : rs2_rdata;
  end

  // load_use_stall is already masked by stall_ex, so flush is the only bubble source
  // that can coincide with a downstream freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_id2ex_ff    <= 1'b0;
      pc_id2ex_ff       <= '0;
      rs1_id2ex_ff      <= '0;
      rs2_id2ex_ff      <= '0;
      rd_id2ex_ff       <= '0;
      rs1_data_id2ex_ff <= '0;
      rs2_data_id2ex_ff <= '0;
      imm_id2ex_ff      <= '0;
      ctrl_id2ex_ff     <= '0;
    end else if (bubble) begin
      valid_id2ex_ff    <= 1'b0;
      pc_id2ex_ff       <= '0;
      rs1_id2ex_ff      <= '0;
      rs2_id2ex_ff      <= '0;
      rd_id2ex_ff       <= '0;
      rs1_data_id2ex_ff <= '0;
      rs2_data_id2ex_ff <= '0;
      imm_id2ex_ff      <= '0;
      ctrl_id2ex_ff     <= '0;
    end else if (!stall_ex) begin
      valid_id2ex_ff    <= valid_id;
      pc_id2ex_ff       <= pc_id;
      rs1_id2ex_ff      <= rs1_id;
      rs2_id2ex_ff      <= rs2_id;
      rd_id2ex_ff       <= valid_id ? rd_id : '0;
      rs1_data_id2ex_ff <= rs1_operand;
      rs2_data_id2ex_ff <= rs2_operand;
      imm_id2ex_ff      <= imm_id;
      ctrl_id2ex_ff     <= valid_id ? ctrl_id : '0;
    end
  end

endmodule
